// File: rtl/cmp_serial_32.sv
// cmp_serial_32: bit-serial MSB-first unsigned magnitude comparator, DIGIT bits per cycle
module cmp_serial_32 #(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, next;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] da, db;
  logic diff, last, accept;
  always_comb begin
    da     = sa[WIDTH-1 -: DIGIT];
    db     = sb[WIDTH-1 -: DIGIT];
    diff   = da != db;
    last   = cnt == CW'(N - 1);
    accept = start && state != RUN;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    if (state == RUN) next = (EARLY_EXIT && diff) || last ? FIN : RUN;
    else next = start ? RUN : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
  end
  // Once gt/lt is set, later digits are ignored so the first (most significant) difference wins
  always_ff @(posedge clk) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      gt  <= 1'b0;
      lt  <= 1'b0;
      eq  <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      cnt <= '0;
      gt  <= 1'b0;
      lt  <= 1'b0;
      eq  <= 1'b0;
    end else if (state == RUN) begin
      sa  <= sa << DIGIT;
      sb  <= sb << DIGIT;
      cnt <= cnt + CW'(1);
      if (!gt && !lt) begin
        gt <= da > db;
        lt <= da < db;
        eq <= last && !diff;
      end
    end
  end
endmodule

// File: tb/tb_cmp_serial_32.sv
// tb_cmp_serial_32: directed checks of the serial comparator, default and DIGIT=4 builds
module tb_cmp_serial_32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy0, done0, gt0, lt0, eq0;
  logic busy1, done1, gt1, lt1, eq1;
  logic busy2, done2, gt2, lt2, eq2;
  logic [4:0] o;
  int sel = 0, checks = 0, errors = 0, lat, bc;

  always #5 clk = ~clk;

  cmp_serial_32 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0));
  cmp_serial_32 #(.DIGIT(4), .EARLY_EXIT(1'b0)) dut4e0 (.clk(clk), .rst(rst), .start(start4),
    .a(a), .b(b), .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1));
  cmp_serial_32 #(.DIGIT(4), .EARLY_EXIT(1'b1)) dut4e1 (.clk(clk), .rst(rst), .start(start4),
    .a(a), .b(b), .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2));

  always_comb
    o = sel == 0 ? {busy0, done0, gt0, lt0, eq0} :
        sel == 1 ? {busy1, done1, gt1, lt1, eq1} : {busy2, done2, gt2, lt2, eq2};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one comparison, return cycles from START sample to DONE and BUSY-high cycle count
  task automatic run(input logic [31:0] xa, input logic [31:0] xb, input int s);
    sel = s;
    a = xa;
    b = xb;
    if (s == 0) start = 1'b1; else start4 = 1'b1;
    step();
    start = 1'b0;
    start4 = 1'b0;
    lat = 0;
    bc = int'(o[4]);
    while (!o[3] && lat < 100) begin
      step();
      lat++;
      bc += int'(o[4]);
    end
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("reset_outputs", 32'(o), 32'h0);

    run(32'hFFFF_FFFF, 32'h0000_FFFF, 0);
    chk("gt_early_lat", lat, 1);
    chk("gt_early_flags", 32'(o[2:0]), 32'b100);
    chk("gt_early_busy_cycles", bc, 1);
    step();

    run(32'h0000_0000, 32'h0000_0001, 0);
    chk("lt_lsb_lat", lat, 32);
    chk("lt_lsb_flags", 32'(o[2:0]), 32'b010);
    step();

    run(32'h0000_FFFF, 32'hFFFF_FFFF, 0);
    chk("lt_early_lat", lat, 1);
    chk("lt_early_flags", 32'(o[2:0]), 32'b010);
    step();

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("eq_ones_lat", lat, 32);
    chk("eq_ones_flags", 32'(o[2:0]), 32'b001);
    step();
    chk("eq_done_one_cycle", 32'(o[3]), 32'h0);
    repeat (10) step();
    chk("eq_flags_held", 32'(o[3:0]), 32'b0001);

    run(32'h0000_0000, 32'h0000_0000, 0);
    chk("eq_zero_lat", lat, 32);
    chk("eq_zero_flags", 32'(o[2:0]), 32'b001);
    step();

    run(32'h0000_1234, 32'h0000_1233, 0);
    chk("gt_late_lat", lat, 30);
    chk("gt_late_flags", 32'(o[2:0]), 32'b100);
    step();

    run(32'h8000_0000, 32'h7FFF_FFFF, 1);
    chk("d4_full_lat", lat, 8);
    chk("d4_full_flags", 32'(o[2:0]), 32'b100);
    step();
    step();
    run(32'h8000_0000, 32'h7FFF_FFFF, 2);
    chk("d4_early_lat", lat, 1);
    chk("d4_early_flags", 32'(o[2:0]), 32'b100);
    step();
    step();

    sel = 0;
    a = 32'h0;
    b = 32'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    a = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 5;
    while (!o[3] && lat < 100) begin
      step();
      lat++;
    end
    chk("ignore_start_lat", lat, 32);
    chk("ignore_start_flags", 32'(o[2:0]), 32'b001);

    a = 32'hFFFF_FFFF;
    b = 32'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_accept", 32'(o), 32'b10000);
    step();
    chk("b2b_result", 32'(o[3:0]), 32'b1100);
    step();

    a = 32'h5A5A_5A5A;
    b = 32'h5A5A_5A5A;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("mid_reset_outputs", 32'(o), 32'h0);
    run(32'h5A5A_5A5A, 32'h5A5A_5A5A, 0);
    chk("post_reset_lat", lat, 32);
    chk("post_reset_flags", 32'(o[2:0]), 32'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
